// File: rtl/req_rr_arb_node.sv
// Round-robin arbiter node: N masters share one TCDM-style target port.
// Each accepted winner is tracked through a fixed-latency pipeline so its response is routed back.
module req_rr_arb_node #(
    parameter int N_MASTER   = 4,
    parameter int LOG_MASTER = $clog2(N_MASTER),
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RESP_LAT   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [LOG_MASTER-1:0]                RR_FLAG_i,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic [N_MASTER-1:0]                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
    output logic                                 data_req_o,
    output logic [ADDR_WIDTH-1:0]                data_add_o,
    output logic                                 data_wen_o,
    output logic [DATA_WIDTH-1:0]                data_wdata_o,
    output logic [BE_WIDTH-1:0]                  data_be_o,
    input  logic                                 data_gnt_i,
    input  logic                                 data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
    output logic                                 resp_err_o
);

    logic [LOG_MASTER-1:0]                startIdx;
    logic [LOG_MASTER-1:0]                candIdx;
    logic [LOG_MASTER-1:0]                winnerIdx;
    logic                                 winnerFound;
    logic                                 accept;

    logic [RESP_LAT-1:0]                  pipeValid_q, pipeValid_d;
    logic [RESP_LAT-1:0][LOG_MASTER-1:0]  pipeId_q, pipeId_d;
    logic                                 respErr_q, respErr_d;
    logic                                 tailValid;
    logic [LOG_MASTER-1:0]                tailId;

    // An out-of-range pointer (non-power-of-two N) restarts the search at master 0.
    always_comb begin
        startIdx    = (int'(RR_FLAG_i) >= N_MASTER) ? '0 : RR_FLAG_i;
        winnerIdx   = '0;
        winnerFound = 1'b0;
        candIdx     = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            candIdx = LOG_MASTER'((int'(startIdx) + k) % N_MASTER);
            if (!winnerFound && data_req_i[candIdx]) begin
                winnerFound = 1'b1;
                winnerIdx   = candIdx;
            end
        end
    end

    always_comb begin
        data_req_o   = |data_req_i;
        data_add_o   = '0;
        data_wen_o   = 1'b0;
        data_wdata_o = '0;
        data_be_o    = '0;
        data_gnt_o   = '0;
        if (winnerFound) begin
            data_add_o            = data_add_i[winnerIdx];
            data_wen_o            = data_wen_i[winnerIdx];
            data_wdata_o          = data_wdata_i[winnerIdx];
            data_be_o             = data_be_i[winnerIdx];
            data_gnt_o[winnerIdx] = data_gnt_i;
        end
    end

    assign accept    = data_req_o & data_gnt_i;
    assign tailValid = pipeValid_q[RESP_LAT-1];
    assign tailId    = pipeId_q[RESP_LAT-1];

    // The response pipeline never stalls; every cycle pushes either an accept or a bubble.
    always_comb begin
        pipeValid_d    = '0;
        pipeId_d       = '0;
        pipeValid_d[0] = accept;
        pipeId_d[0]    = accept ? winnerIdx : '0;
        for (int s = 1; s < RESP_LAT; s++) begin
            pipeValid_d[s] = pipeValid_q[s-1];
            pipeId_d[s]    = pipeId_q[s-1];
        end
        respErr_d = respErr_q | (data_r_valid_i != tailValid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeValid_q <= '0;
            pipeId_q    <= '0;
            respErr_q   <= 1'b0;
        end else begin
            pipeValid_q <= pipeValid_d;
            pipeId_q    <= pipeId_d;
            respErr_q   <= respErr_d;
        end
    end

    // An unexpected target response is flagged but never routed to a master.
    always_comb begin
        data_r_valid_o = '0;
        if (tailValid) begin
            data_r_valid_o[tailId] = 1'b1;
        end
    end

    assign data_r_rdata_o = data_r_rdata_i;
    assign resp_err_o     = respErr_q;

endmodule

// File: tb/tb_req_rr_arb_node.sv
// Randomized bench for req_rr_arb_node, checked against a scheduled-response model.
module tb_req_rr_arb_node;

    localparam int N   = 4;
    localparam int LG  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LAT = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [LG-1:0]         rrFlag;
    logic [N-1:0]          req;
    logic [N-1:0][AW-1:0]  add;
    logic [N-1:0]          wen;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0][BW-1:0]  be;
    logic [N-1:0]          gntOut;
    logic [N-1:0]          rvalidOut;
    logic [DW-1:0]         rdataOut;
    logic                  reqOut;
    logic [AW-1:0]         addOut;
    logic                  wenOut;
    logic [DW-1:0]         wdataOut;
    logic [BW-1:0]         beOut;
    logic                  gntIn;
    logic                  rvalidIn;
    logic [DW-1:0]         rdataIn;
    logic                  errOut;

    typedef struct {
        int due;
        int id;
    } resp_t;

    resp_t pending[$];
    int    cycle   = 0;
    int    total   = 0;
    int    bad     = 0;
    int    flagCnt = 0;
    bit    expErr  = 1'b0;

    always #5 clk = ~clk;

    req_rr_arb_node #(
        .N_MASTER(N), .LOG_MASTER(LG), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BE_WIDTH(BW), .RESP_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .RR_FLAG_i(rrFlag),
        .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be),
        .data_gnt_o(gntOut), .data_r_valid_o(rvalidOut), .data_r_rdata_o(rdataOut),
        .data_req_o(reqOut), .data_add_o(addOut), .data_wen_o(wenOut),
        .data_wdata_o(wdataOut), .data_be_o(beOut),
        .data_gnt_i(gntIn), .data_r_valid_i(rvalidIn), .data_r_rdata_i(rdataIn),
        .resp_err_o(errOut)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d: got %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    // Winner is the requester closest to the pointer going upward, wrapping around.
    function automatic int modelWinner(input logic [N-1:0] r, input int flag);
        int start;
        int best;
        int bestDist;
        int d;
        start    = (flag >= N) ? 0 : flag;
        best     = -1;
        bestDist = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - start + N) % N;
                if (d < bestDist) begin
                    bestDist = d;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    // flagSel < 0 uses the modelled external counter; rvalidSel < 0 makes the target well-behaved.
    task automatic applyStimulus(input logic [N-1:0] reqV, input logic gntV,
                                 input int flagSel, input int rvalidSel);
        int           win;
        int           flagUsed;
        int           tailId;
        logic         tailValid;
        logic         accepted;
        logic [N-1:0] expGnt;
        logic [N-1:0] expRv;
        resp_t        e;
        for (int m = 0; m < N; m++) begin
            add[m]   = $urandom;
            wdata[m] = $urandom;
            be[m]    = BW'($urandom);
            wen[m]   = 1'($urandom);
        end
        rdataIn   = $urandom;
        flagUsed  = (flagSel >= 0) ? flagSel : flagCnt;
        rrFlag    = LG'(flagUsed);
        req       = reqV;
        gntIn     = gntV;
        tailValid = 1'b0;
        tailId    = 0;
        foreach (pending[j]) begin
            if (pending[j].due == cycle) begin
                tailValid = 1'b1;
                tailId    = pending[j].id;
            end
        end
        rvalidIn = (rvalidSel >= 0) ? (rvalidSel != 0) : tailValid;
        win      = modelWinner(reqV, flagUsed);

        @(negedge clk);
        expGnt = '0;
        expRv  = '0;
        if (win >= 0) expGnt[win] = gntV;
        if (tailValid) expRv[tailId] = 1'b1;
        checkOutput("gnt",    gntOut,    expGnt);
        checkOutput("reqOut", reqOut,    |reqV);
        checkOutput("add",    addOut,    (win >= 0) ? add[win] : '0);
        checkOutput("wen",    wenOut,    (win >= 0) ? wen[win] : 1'b0);
        checkOutput("wdata",  wdataOut,  (win >= 0) ? wdata[win] : '0);
        checkOutput("be",     beOut,     (win >= 0) ? be[win] : '0);
        checkOutput("rvalid", rvalidOut, expRv);
        checkOutput("rdata",  rdataOut,  rdataIn);
        checkOutput("err",    errOut,    expErr);
        accepted = (win >= 0) && gntV;

        @(posedge clk);
        if (rvalidIn != tailValid) expErr = 1'b1;
        while (pending.size() > 0 && pending[0].due <= cycle) void'(pending.pop_front());
        if (accepted) begin
            e.due = cycle + LAT;
            e.id  = win;
            pending.push_back(e);
            flagCnt = (flagCnt + 1) % N;
        end
        cycle++;
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic doReset();
        #2;
        rst_n    = 1'b0;
        req      = '0;
        gntIn    = 1'b0;
        rvalidIn = 1'b0;
        #1;
        pending.delete();
        expErr  = 1'b0;
        flagCnt = 0;
        checkOutput("rstValid", rvalidOut, '0);
        checkOutput("rstErr",   errOut,    1'b0);
        @(posedge clk);
        cycle++;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rrFlag   = '0;
        req      = '0;
        add      = '0;
        wen      = '0;
        wdata    = '0;
        be       = '0;
        gntIn    = 1'b0;
        rvalidIn = 1'b0;
        rdataIn  = '0;
        @(posedge clk);
        #1;
        doReset();

        // Rotation with the counter advancing on each accept.
        repeat (8) applyStimulus(4'b1111, 1'b1, -1, -1);
        repeat (LAT + 1) applyStimulus(4'b0000, 1'b0, -1, -1);

        // Pointer wrap-around.
        applyStimulus(4'b0011, 1'b1, 3, -1);
        applyStimulus(4'b0011, 1'b1, 2, -1);
        repeat (LAT + 1) applyStimulus(4'b0000, 1'b0, -1, -1);

        // Target stall then grant.
        repeat (3) applyStimulus(4'b0100, 1'b0, -1, -1);
        applyStimulus(4'b0100, 1'b1, -1, -1);
        repeat (LAT + 2) applyStimulus(4'b0000, 1'b0, -1, -1);

        // Back-to-back accepts from masters 1, 3, 1.
        applyStimulus(4'b0010, 1'b1, -1, -1);
        applyStimulus(4'b1000, 1'b1, -1, -1);
        applyStimulus(4'b0010, 1'b1, -1, -1);
        repeat (LAT + 2) applyStimulus(4'b0000, 1'b0, -1, -1);

        // Random traffic, mostly counter-driven pointer with occasional arbitrary values.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(N'($urandom), 1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1, -1);
        end

        // Reset with the pipeline full, then confirm nothing stale comes out.
        repeat (LAT) applyStimulus(4'b1111, 1'b1, -1, -1);
        doReset();
        repeat (LAT + 2) applyStimulus(4'b0000, 1'b0, -1, -1);

        // Unsolicited target response sets the sticky error.
        applyStimulus(4'b0000, 1'b0, -1, 1);
        repeat (4) applyStimulus(4'b0000, 1'b0, -1, -1);
        applyStimulus(4'b1010, 1'b1, -1, -1);
        repeat (LAT + 1) applyStimulus(4'b0000, 1'b0, -1, -1);
        doReset();
        repeat (2) applyStimulus(4'b0000, 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/req_rr_arb_node.md
# req_rr_arb_node

Round-robin request arbiter node joining N_MASTER initiators onto one TCDM-style target port with grant-based flow control. Priority pointer comes from an external round-robin flag counter that advances on every accepted transfer (`data_req_o & data_gnt_i`), sitting directly upstream of this node. Tracks each accepted request's winner index through a fixed-latency response pipeline and routes the read response back to the originating master.

## Interface
- N_MASTER, 4, number of initiators (2..16)
- LOG_MASTER, $clog2(N_MASTER), width of index and RR flag
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8
- RESP_LAT, 1, cycles from accepted request to response (1..4)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- RR_FLAG_i  in  LOG_MASTER  round-robin priority pointer
- data_req_i  in  N_MASTER  per-master request
- data_add_i  in  N_MASTER x ADDR_WIDTH  per-master address
- data_wen_i  in  N_MASTER  per-master write-enable, active-low (0 = write)
- data_wdata_i  in  N_MASTER x DATA_WIDTH  per-master write data
- data_be_i  in  N_MASTER x BE_WIDTH  per-master byte enables
- data_gnt_o  out  N_MASTER  per-master grant
- data_r_valid_o  out  N_MASTER  per-master response valid
- data_r_rdata_o  out  DATA_WIDTH  response data, shared by all masters
- data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o  out  1/ADDR/1/DATA/BE  target-side request
- data_gnt_i  in  1  target grant
- data_r_valid_i  in  1  target response valid
- data_r_rdata_i  in  DATA_WIDTH  target response data
- resp_err_o  out  1  sticky: target response disagreed with the tracking pipeline

## Operation
- Arbitration is combinational. Search starts at index RR_FLAG_i and proceeds upward with wrap-around. The first asserted data_req_i wins.
- RR_FLAG_i >= N_MASTER (non-power-of-two N) is treated as 0.
- data_req_o = OR of data_req_i. Address, wen, wdata and be of the winner are forwarded. With no request, all forwarded fields are 0.
- data_gnt_o[winner] = data_gnt_i. All other grants are 0. A grant is never asserted without the matching request.
- Accepted transfer = data_req_o & data_gnt_i. It pushes {valid=1, ID=winner} into stage 0 of a RESP_LAT-deep shift pipeline. Any other cycle pushes valid=0.
- The pipeline shifts every cycle; it never stalls.
- Tail stage valid=1 drives data_r_valid_o[tail ID]=1. All other data_r_valid_o are 0.
- data_r_rdata_o = data_r_rdata_i, passed through combinationally and unqualified.
- Responses are produced for both reads and writes (write = ack only).
- resp_err_o sets when data_r_valid_i != tail valid in any cycle. It stays set until reset.
- When the tail is invalid, the response is not routed, even if data_r_valid_i=1.
- Reset, asynchronous and at any time, clears all pipeline valids, IDs and resp_err_o. Transfers in flight are dropped; no response is issued for them.

## Timing
- Reset values: data_r_valid_o=0, resp_err_o=0. Combinational outputs follow their inputs (all 0 with no requests).
- Request path: zero-cycle latency (combinational req/gnt).
- Response: data_r_valid_o asserted exactly RESP_LAT cycles after the accepting edge.
- Back-to-back accepts sustain one transfer per cycle. Responses return in order.
- The RR_FLAG_i update from an accept is visible to arbitration in the next cycle.
- A new request and the response of an earlier request in the same cycle are independent. Both complete, even for the same master.

## Test plan
- Reset: rst_n=0 mid-burst with pipeline full -> data_r_valid_o=0, resp_err_o=0 immediately. No stale responses after release.
- Rotation: N=4, all req=1111, gnt=1, external flag counting 0,1,2,3,0 -> grants one-hot 0001,0010,0100,1000,0001. data_r_valid_o follows the same sequence delayed by RESP_LAT.
- Priority wrap: RR_FLAG_i=3, req=0011 -> data_gnt_o=0001, data_add_o=master0 address. RR_FLAG_i=2, req=0011 -> gnt=0001.
- Target stall: req=0100, gnt_i=0 for 3 cycles then 1 -> no pipeline entry while stalled. One data_r_valid_o[2] pulse RESP_LAT cycles after the grant cycle.
- Latency: RESP_LAT=3, back-to-back accepts from masters 1,3,1 -> data_r_valid_o=0010,1000,0010 on cycles +3,+4,+5. rdata passed through unchanged.
- Error: data_r_valid_i=1 with empty pipeline -> resp_err_o=1 the next cycle, held until reset. No data_r_valid_o pulse.
